uart_tx_fifo: RTL and testbench

//   Buffered UART transmitter: the transmit-side counterpart of uart_rx.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1/8N2 UART transmitter with input FIFO
//
// Bytes enter through a valid/ready handshake into a FIFO_DEPTH-entry queue.
// The FSM pops the head byte and serialises it LSB first as start, data and
// stop bits, each bit held BAUD_DIV = CLK_CYCLES/BAUD_RATE clock cycles.
//
// Ports:
//   clk_i             system clock
//   rst_i             asynchronous reset, active-high
//   tx_byte_i         byte to queue
//   tx_valid_i        tx_byte_i valid
//   tx_ready_o        FIFO can accept (registered count < FIFO_DEPTH)
//   tx_o              registered serial line, idle high
//   is_transmitting_o FSM not in IDLE
//   tx_done_o         one-cycle pulse at the end of each frame's last stop bit
//   fifo_count_o      entries currently queued
module uart_tx_fifo #(
  parameter int CLK_CYCLES = 100_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         tx_byte_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          is_transmitting_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BAUD_DIV = CLK_CYCLES / BAUD_RATE;
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CW       = $clog2(STOP_LEN + 1);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_WIDTH - 1);
  localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           baud_q, baud_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    push, pop;

  // Ready comes from the registered count only, so a same-cycle pop never
  // lets a full FIFO accept.
  assign tx_ready_o        = !rst_i && (count_q < DEPTH);
  assign push              = tx_valid_i && tx_ready_o;
  assign tx_o              = tx_q;
  assign tx_done_o         = done_q;
  assign is_transmitting_o = (state_q != IDLE);
  assign fifo_count_o      = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_MAX) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit so bursts have no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (pop && !push) count_d = count_q - (PW + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_byte_i;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_i;
  logic [7:0] byte1, byte2;
  logic       valid1, valid2;
  logic       ready1, tx1, istx1, done1;
  logic       ready2, tx2, istx2, done2;
  logic [4:0] cnt1, cnt2;

  uart_tx_fifo #(.CLK_CYCLES(16), .BAUD_RATE(1), .DATA_WIDTH(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_byte_i(byte1), .tx_valid_i(valid1), .tx_ready_o(ready1),
    .tx_o(tx1), .is_transmitting_o(istx1), .tx_done_o(done1), .fifo_count_o(cnt1));

  uart_tx_fifo #(.CLK_CYCLES(16), .BAUD_RATE(1), .DATA_WIDTH(8), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .tx_byte_i(byte2), .tx_valid_i(valid2), .tx_ready_o(ready2),
    .tx_o(tx2), .is_transmitting_o(istx2), .tx_done_o(done2), .fifo_count_o(cnt2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb[$];
  logic [8:0] rxq[$];
  int         doneq[$];
  int         rx_rd = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent line decoder: samples mid-bit, records bytes and done times.
  initial begin
    bit         m_act = 1'b0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_byte = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        m_act = 1'b0;
        m_cnt = 0;
      end else begin
        if (done1) doneq.push_back(cyc);
        if (!m_act && tx1 == 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
          m_err = 1'b0;
        end
        if (m_act) begin
          if (m_cnt % 16 == 8) begin
            if (m_cnt / 16 == 0) begin
              if (tx1 !== 1'b0) m_err = 1'b1;
            end else if (m_cnt / 16 <= 8) begin
              m_byte[m_cnt/16-1] = tx1;
            end else begin
              if (tx1 !== 1'b1) m_err = 1'b1;
              rxq.push_back({m_err, m_byte});
              m_act = 1'b0;
            end
          end
          m_cnt++;
        end
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[i-1];
    else return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input int budget, output int t_acc);
    bit acc;
    t_acc  = -1;
    byte1  = b;
    valid1 = 1'b1;
    for (int i = 0; i < budget; i++) begin
      acc = ready1;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        sb.push_back(b);
        t_acc = cyc;
        break;
      end
    end
    valid1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cnt1 == 0 && !istx1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    logic [7:0] e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (rx_rd < rxq.size()) begin
        chk(tag, rxq[rx_rd], {1'b0, e});
        rx_rd++;
      end else begin
        chk({tag, "_missing"}, 32'hDEAD, {24'h0, e});
      end
    end
  endtask

  initial begin
    int t, t_first, d0;
    bit all_high, no_done;

    rst_i  = 1'b1;
    valid1 = 1'b0;
    valid2 = 1'b0;
    byte1  = '0;
    byte2  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx1, 1'b1);
    chk("rst_cnt", cnt1, 0);
    chk("rst_ready", ready1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_istx", istx1, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", ready1, 1'b1);
    chk("rel_ready2", ready2, 1'b1);
    repeat (4) @(negedge clk);
    chk("rel_tx", tx1, 1'b1);

    // Single byte 0x6D with exact bit timing
    send(8'h6D, 4, t);
    chk("b1_accept", (t >= 0), 1'b1);
    byte1 = 8'h00;
    chk("b1_tx_before_pop", tx1, 1'b1);
    chk("b1_cnt_before_pop", cnt1, 1);
    for (int c = 0; c <= 161; c++) begin
      @(negedge clk);
      if (c % 16 == 0 || c % 16 == 15) chk($sformatf("b1_tx_c%0d", c), tx1, frame_bit(8'h6D, c / 16));
      if (c >= 159) chk($sformatf("b1_done_c%0d", c), done1, (c == 160));
    end
    compare_rx("b1_rx");

    // Burst of 17 from idle, then the 18th under backpressure
    wait_idle("burst_pre_idle", 50);
    d0 = doneq.size();
    send(8'($urandom_range(0, 255)), 2, t_first);
    chk("burst_acc_0", (t_first >= 0), 1'b1);
    for (int i = 1; i < 17; i++) begin
      send(8'($urandom_range(0, 255)), 1, t);
      chk($sformatf("burst_acc_%0d", i), (t == t_first + i), 1'b1);
    end
    chk("burst_cnt_full", cnt1, 16);
    chk("burst_ready_full", ready1, 1'b0);
    send(8'hC3, 300, t);
    chk("burst_18th_time", t - t_first, 162);
    wait_idle("burst_drain", 3500);
    compare_rx("burst_rx");
    chk("burst_done_count", doneq.size() - d0, 18);
    for (int i = 1; i < 18 && d0 + i < doneq.size(); i++)
      chk($sformatf("burst_done_gap_%0d", i), doneq[d0+i] - doneq[d0+i-1], 160);

    // Back-to-back 0x00 then 0xFF: push and pop in the same cycle
    d0 = doneq.size();
    send(8'h00, 2, t);
    send(8'hFF, 1, t);
    for (int c = 0; c <= 321; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) chk("b2b_cnt_pushpop", cnt1, 1);
      if (c % 16 == 0 || c % 16 == 15)
        chk($sformatf("b2b_tx_c%0d", c), tx1,
            (c < 160) ? frame_bit(8'h00, c / 16) : frame_bit(8'hFF, (c - 160) / 16));
      if (c == 160 || c == 320) chk($sformatf("b2b_done_c%0d", c), done1, 1'b1);
    end
    chk("b2b_done_count", doneq.size() - d0, 2);
    if (doneq.size() - d0 >= 2) chk("b2b_done_gap", doneq[d0+1] - doneq[d0], 160);
    compare_rx("b2b_rx");

    // Reset during DATA bit 3 with 4 bytes queued
    wait_idle("rst_pre_idle", 50);
    send(8'h11, 2, t);
    send(8'h22, 1, t);
    send(8'h33, 1, t);
    send(8'h44, 1, t);
    repeat (67) @(negedge clk);
    chk("mid_istx", istx1, 1'b1);
    chk("mid_cnt", cnt1, 3);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_tx", tx1, 1'b1);
    chk("mid_rst_cnt", cnt1, 0);
    chk("mid_rst_istx", istx1, 1'b0);
    chk("mid_rst_ready", ready1, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    rx_rd = rxq.size();
    chk("mid_rel_ready", ready1, 1'b1);
    all_high = 1'b1;
    no_done  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) all_high = 1'b0;
      if (done1 !== 1'b0) no_done = 1'b0;
    end
    chk("post_rst_tx_high", all_high, 1'b1);
    chk("post_rst_no_done", no_done, 1'b1);
    chk("post_rst_cnt", cnt1, 0);
    chk("post_rst_rx_none", rxq.size() - rx_rd, 0);

    // Two stop bits, byte 0xA5
    @(negedge clk);
    byte2  = 8'hA5;
    valid2 = 1'b1;
    chk("s2_ready", ready2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    byte2  = 8'h00;
    for (int c = 0; c <= 177; c++) begin
      @(negedge clk);
      if (c % 16 == 0 || c % 16 == 15) chk($sformatf("s2_tx_c%0d", c), tx2, frame_bit(8'hA5, c / 16));
      if (c >= 175) chk($sformatf("s2_done_c%0d", c), done2, (c == 176));
      if (c == 175 || c == 176) chk($sformatf("s2_istx_c%0d", c), istx2, (c == 175));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
